// File: rtl/op_sequencer_if.sv
// Operand-select bus between the instruction issue unit (master) and the cpu (slave).
// The master drives the operation and register addresses; the cpu answers with
// its result word and flags.
interface op_sequencer_if;
  logic [3:0]  Op;
  logic [2:0]  Op1;
  logic [2:0]  Op2;
  logic [15:0] Y;
  logic        C;
  logic        V;
  logic        Z;

  modport master (output Op, Op1, Op2, input Y, C, V, Z);
  modport slave  (input Op, Op1, Op2, output Y, C, V, Z);
endinterface

// File: rtl/op_sequencer.sv
// Instruction issue unit: fetches 10-bit words from a small writable program
// memory, issues ALU/load/store operations to the cpu for exactly one cycle,
// captures the cpu response, and executes jump / branch-on-zero / halt locally.
// PC_WIDTH must not exceed 6 (jump targets come from the 6-bit {Op1,Op2} field)
// and DEPTH must equal 2**PC_WIDTH so the pc wraps naturally.
module op_sequencer #(
  parameter int PC_WIDTH = 5,
  parameter int DEPTH    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                prog_we,
  input  logic [PC_WIDTH-1:0] prog_addr,
  input  logic [9:0]          prog_data,
  op_sequencer_if.master      cpu,
  output logic [15:0]         result_data,
  output logic [2:0]          result_flags,
  output logic                result_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic [15:0]         retired,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Sequencer-local opcodes; these never reach the cpu.
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [3:0] OP_JMP  = 4'b1101;
  localparam logic [3:0] OP_BZ   = 4'b1100;

  state_t              state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [15:0]         retired_reg, retired_next;
  logic [3:0]          op_reg, op_next;
  logic [2:0]          op1_reg, op1_next;
  logic [2:0]          op2_reg, op2_next;
  logic [15:0]         result_data_reg;
  logic [2:0]          result_flags_reg;
  logic                result_valid_reg;
  logic [9:0]          instr_reg;
  logic                busy_int;

  // Program memory; not cleared by reset so a loaded program survives it.
  logic [9:0] mem [DEPTH];

  assign busy_int = (state_reg == FETCH) || (state_reg == DECODE) || (state_reg == EXEC);

  // Program load port, locked out while a program is running.
  always_ff @(posedge clk) begin
    if (prog_we && !busy_int) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Registered instruction fetch; only consumed in DECODE right after FETCH.
  always_ff @(posedge clk) begin
    if (state_reg == FETCH) begin
      instr_reg <= mem[pc_reg];
    end
  end

  // State, pc, retire counter and the registered cpu drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pc_reg      <= '0;
      retired_reg <= '0;
      op_reg      <= '0;
      op1_reg     <= '0;
      op2_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      retired_reg <= retired_next;
      op_reg      <= op_next;
      op1_reg     <= op1_next;
      op2_reg     <= op2_next;
    end
  end

  // Next-state logic; the cpu sees a non-idle word only while in EXEC.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    retired_next = retired_reg;
    op_next      = 4'b0000;
    op1_next     = 3'b000;
    op2_next     = 3'b000;
    case (state_reg)
      IDLE: begin
        if (start) begin
          pc_next    = '0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = DECODE;
      end
      DECODE: begin
        case (instr_reg[9:6])
          OP_HALT: begin
            state_next = DONE;
          end
          OP_JMP: begin
            pc_next    = PC_WIDTH'(instr_reg[5:0]);
            state_next = FETCH;
          end
          OP_BZ: begin
            // Branches on the Z captured by the last EXEC, never on live Z.
            if (result_flags_reg[0]) begin
              pc_next = PC_WIDTH'(instr_reg[5:0]);
            end else begin
              pc_next = pc_reg + 1'b1;
            end
            state_next = FETCH;
          end
          default: begin
            // Load the drive registers so the word is stable for the whole EXEC cycle.
            op_next    = instr_reg[9:6];
            op1_next   = instr_reg[5:3];
            op2_next   = instr_reg[2:0];
            state_next = EXEC;
          end
        endcase
      end
      EXEC: begin
        pc_next      = pc_reg + 1'b1;
        retired_next = retired_reg + 16'd1;
        state_next   = FETCH;
      end
      DONE: begin
        if (start) begin
          pc_next      = '0;
          retired_next = '0;
          state_next   = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the cpu response at the edge that closes EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_data_reg  <= '0;
      result_flags_reg <= '0;
      result_valid_reg <= 1'b0;
    end else begin
      result_valid_reg <= (state_reg == EXEC);
      if (state_reg == EXEC) begin
        result_data_reg  <= cpu.Y;
        result_flags_reg <= {cpu.C, cpu.V, cpu.Z};
      end
    end
  end

  assign cpu.Op       = op_reg;
  assign cpu.Op1      = op1_reg;
  assign cpu.Op2      = op2_reg;
  assign result_data  = result_data_reg;
  assign result_flags = result_flags_reg;
  assign result_valid = result_valid_reg;
  assign pc           = pc_reg;
  assign retired      = retired_reg;
  assign busy         = busy_int;
  assign done         = (state_reg == DONE);

endmodule
